// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-index width, register count and x0 index.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/cpu_regfile_rdport.sv
// One combinational read port of the integer register file.
// x0 reads as zero; a same-cycle write to the addressed register is forwarded.
module cpu_regfile_rdport
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [NUM_REGS-1:1][XLEN-1:0] i_regs,
  input  reg_addr_t                     i_addr,
  input  logic                          i_byp_en,
  input  reg_addr_t                     i_byp_addr,
  input  logic [XLEN-1:0]               i_byp_data,
  output logic [XLEN-1:0]               o_data_c
);

  // Select zero, bypassed write data or stored value
  always_comb begin
    o_data_c = '0;
    if (i_addr == REG_ZERO) begin
      o_data_c = '0;
    end else if (i_byp_en && (i_byp_addr == i_addr)) begin
      o_data_c = i_byp_data;
    end else begin
      o_data_c = i_regs[i_addr];
    end
  end

endmodule : cpu_regfile_rdport

// File: rtl/cpu_regfile.sv
// Integer register file: x0..x31, two combinational read ports, one write port.
// x0 has no storage and always reads zero. Writes are forwarded to readers in
// the same cycle. Optional write trace enabled by defining CPU_REGFILE_LOG_EN.
module cpu_regfile
  import cpu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  rd_write_en,
  output logic [XLEN-1:0]       rs1_data,
  output logic [XLEN-1:0]       rs2_data
);

  logic [NUM_REGS-1:1][XLEN-1:0] r_regs;
  logic                          w_wr_active;

  // A write takes effect only when enabled, not to x0 and not under reset
  assign w_wr_active = rd_write_en && (rd_addr != REG_ZERO) && !reset;

  // Storage update: reset clears x1..x31 and wins over a concurrent write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regs <= '0;
    end else if (w_wr_active) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  cpu_regfile_rdport #(.XLEN(XLEN)) u_rdport1 (
    .i_regs     (r_regs),
    .i_addr     (rs1_addr),
    .i_byp_en   (w_wr_active),
    .i_byp_addr (rd_addr),
    .i_byp_data (rd_data),
    .o_data_c   (rs1_data)
  );

  cpu_regfile_rdport #(.XLEN(XLEN)) u_rdport2 (
    .i_regs     (r_regs),
    .i_addr     (rs2_addr),
    .i_byp_en   (w_wr_active),
    .i_byp_addr (rd_addr),
    .i_byp_data (rd_data),
    .o_data_c   (rs2_data)
  );

`ifdef CPU_REGFILE_LOG_EN
  // Simulation trace of every enabled write, x0 writes flagged as ignored
  always_ff @(posedge clk) begin
    if (!reset && rd_write_en) begin
      if (rd_addr == REG_ZERO) begin
        $display("%0t cpu_regfile: x%0d <= 0x%h (ignored)", $time, rd_addr, rd_data);
      end else begin
        $display("%0t cpu_regfile: x%0d <= 0x%h", $time, rd_addr, rd_data);
      end
    end
  end
`endif

endmodule : cpu_regfile

// File: tb/tb_cpu_regfile.sv
// Bench for cpu_regfile: a 32-bit and a 64-bit instance driven in lockstep
// with directed vectors and random traffic, checked against a register-array
// model and against hand-computed expectations.
module tb_cpu_regfile;

  typedef struct {
    bit        rst;
    bit        we;
    bit [4:0]  rd;
    bit [63:0] data;
    bit [4:0]  a1;
    bit [4:0]  a2;
    bit [63:0] exp1;
    bit [63:0] exp2;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        rd_write_en;
  logic [63:0] wdata;
  logic [31:0] rs1_data32, rs2_data32;
  logic [63:0] rs1_data64, rs2_data64;

  int total = 0;
  int bad   = 0;

  bit [63:0] model [32];
  vec_t      vq [$];

  always #5 clk = ~clk;

  cpu_regfile #(.XLEN(32)) dut32 (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rd_data     (wdata[31:0]),
    .rd_write_en (rd_write_en),
    .rs1_data    (rs1_data32),
    .rs2_data    (rs2_data32)
  );

  cpu_regfile #(.XLEN(64)) dut64 (
    .clk         (clk),
    .reset       (reset),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rd_addr     (rd_addr),
    .rd_data     (wdata),
    .rd_write_en (rd_write_en),
    .rs1_data    (rs1_data64),
    .rs2_data    (rs2_data64)
  );

  task automatic check(input string name, input bit [63:0] got, input bit [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  // Value a reader must see given the architectural state and the current write
  function automatic bit [63:0] ref_read(input bit [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (!reset && rd_write_en && rd_addr != 5'd0 && rd_addr == a) return wdata;
    return model[a];
  endfunction

  task automatic check_ports(input string tag);
    bit [63:0] e1, e2;
    e1 = ref_read(rs1_addr);
    e2 = ref_read(rs2_addr);
    check({tag, " rs1_32"}, {32'd0, rs1_data32}, {32'd0, e1[31:0]});
    check({tag, " rs2_32"}, {32'd0, rs2_data32}, {32'd0, e2[31:0]});
    check({tag, " rs1_64"}, rs1_data64, e1);
    check({tag, " rs2_64"}, rs2_data64, e2);
  endtask

  // One clock: drive at negedge, check before and after the rising edge
  task automatic step(input bit rst, input bit we, input bit [4:0] rd, input bit [63:0] d,
                      input bit [4:0] a1, input bit [4:0] a2, input string tag);
    reset       = rst;
    rd_write_en = we;
    rd_addr     = rd;
    wdata       = d;
    rs1_addr    = a1;
    rs2_addr    = a2;
    #1;
    check_ports({tag, " pre"});
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (we && rd != 5'd0) begin
      model[rd] = d;
    end
    #1;
    check_ports({tag, " post"});
    @(negedge clk);
  endtask

  task automatic add(input bit rst, input bit we, input bit [4:0] rd, input bit [63:0] d,
                     input bit [4:0] a1, input bit [4:0] a2,
                     input bit [63:0] e1, input bit [63:0] e2);
    vec_t v;
    v.rst = rst; v.we = we; v.rd = rd; v.data = d;
    v.a1 = a1; v.a2 = a2; v.exp1 = e1; v.exp2 = e2;
    vq.push_back(v);
  endtask

  initial begin
    bit        r_rst, r_we;
    bit [4:0]  r_rd, r_a1, r_a2;
    bit [63:0] r_d;

    reset = 1'b1; rd_write_en = 1'b0; rd_addr = '0; wdata = '0;
    rs1_addr = '0; rs2_addr = '0;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;

    // Directed vectors; expectations are the 64-bit post-edge values
    add(1, 0, 0, 64'h0,                  0, 0, 64'h0,                  64'h0);
    add(1, 1, 3, 64'h77,                 3, 0, 64'h0,                  64'h0);
    add(0, 1, 1, 64'h12345678,           1, 2, 64'h12345678,           64'h0);
    add(0, 1, 0, 64'hDEADBEEF,           0, 1, 64'h0,                  64'h12345678);
    add(0, 0, 0, 64'h0,                  0, 0, 64'h0,                  64'h0);
    add(0, 1, 2, 64'hFFFFFFFF,           1, 4, 64'h12345678,           64'h0);
    add(0, 1, 4, 64'hAAAAAAAA,           1, 4, 64'h12345678,           64'hAAAAAAAA);
    add(0, 0, 0, 64'h0,                  2, 4, 64'hFFFFFFFF,           64'hAAAAAAAA);
    add(1, 0, 0, 64'h0,                  1, 2, 64'h0,                  64'h0);
    add(1, 1, 5, 64'h99,                 5, 4, 64'h0,                  64'h0);
    add(0, 0, 0, 64'h0,                  0, 1, 64'h0,                  64'h0);
    add(0, 0, 0, 64'h0,                  2, 3, 64'h0,                  64'h0);
    add(0, 0, 0, 64'h0,                  4, 4, 64'h0,                  64'h0);
    add(0, 1, 5, 64'h55555555,           5, 6, 64'h55555555,           64'h0);
    add(0, 1, 6, 64'hAAAAAAAA,           5, 6, 64'h55555555,           64'hAAAAAAAA);
    add(0, 1, 1, 64'h123456789ABCDEF0,   1, 8, 64'h123456789ABCDEF0,   64'h0);
    add(0, 1, 8, 64'hFFFFFFFFFFFFFFFF,   1, 8, 64'h123456789ABCDEF0,   64'hFFFFFFFFFFFFFFFF);
    add(0, 1, 0, 64'hDEADBEEFDEADBEEF,   0, 0, 64'h0,                  64'h0);
    add(0, 0, 0, 64'h0,                  1, 8, 64'h123456789ABCDEF0,   64'hFFFFFFFFFFFFFFFF);
    add(0, 1, 7, 64'hCAFE,               7, 7, 64'hCAFE,               64'hCAFE);
    add(1, 0, 0, 64'h0,                  7, 8, 64'h0,                  64'h0);
    add(0, 0, 0, 64'h0,                  1, 8, 64'h0,                  64'h0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].rst, vq[i].we, vq[i].rd, vq[i].data, vq[i].a1, vq[i].a2, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl rs1_64", i), rs1_data64, vq[i].exp1);
      check($sformatf("vec%0d tbl rs2_64", i), rs2_data64, vq[i].exp2);
      check($sformatf("vec%0d tbl rs1_32", i), {32'd0, rs1_data32}, {32'd0, vq[i].exp1[31:0]});
      check($sformatf("vec%0d tbl rs2_32", i), {32'd0, rs2_data32}, {32'd0, vq[i].exp2[31:0]});
    end

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      r_rst = ($urandom_range(24) == 0);
      r_we  = ($urandom_range(1) == 1);
      r_rd  = 5'($urandom_range(31));
      r_d   = {$urandom, $urandom};
      r_a1  = ($urandom_range(3) == 0) ? r_rd : 5'($urandom_range(31));
      r_a2  = ($urandom_range(3) == 0) ? r_rd : 5'($urandom_range(31));
      step(r_rst, r_we, r_rd, r_d, r_a1, r_a2, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cpu_regfile
